// File: rtl/rom_stream_reader.sv
// Sweeps a ROM address range, tracks the fixed read latency, buffers words in a FIFO
// and streams them out over valid/ready. Optional checksum built when ROM_STREAM_CHECKSUM_EN is defined.
module rom_stream_reader #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned ROM_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  rom_cs,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [15:0]           checksum
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + ROM_LATENCY + 2) + 1;
    localparam int unsigned NW_W  = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [NW_W-1:0]         issue_left;
    logic [NW_W-1:0]         accept_left;
    logic [ROM_LATENCY-1:0]  tag_sr;
    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_count;

    logic                    push;
    logic                    pop;
    logic [CNT_W-1:0]        tag_count;
    logic [CNT_W-1:0]        outstanding_next;
    logic                    credit_ok;

    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_mem[rd_ptr];
    assign push      = tag_sr[ROM_LATENCY-1];
    assign pop       = out_valid && out_ready;

    // Words owed to the FIFO after this edge, counting this cycle's pop; a new issue needs a free slot.
    always_comb begin
        tag_count = '0;
        for (int i = 0; i < int'(ROM_LATENCY); i++) begin
            tag_count = tag_count + CNT_W'(tag_sr[i]);
        end
        outstanding_next = fifo_count + tag_count + CNT_W'(rom_cs) - CNT_W'(pop);
        credit_ok        = (outstanding_next < CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rom_cs      <= 1'b0;
            rom_addr    <= '0;
            addr_q      <= '0;
            issue_left  <= '0;
            accept_left <= '0;
            tag_sr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            done   <= 1'b0;
            rom_cs <= 1'b0;

            // Latency tracking: a tag leaving the last stage marks rom_dout as valid now.
            for (int i = int'(ROM_LATENCY) - 1; i > 0; i--) begin
                tag_sr[i] <= tag_sr[i-1];
            end
            tag_sr[0] <= rom_cs;

            if (push) begin
                fifo_mem[wr_ptr] <= rom_dout;
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr      <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
                accept_left <= accept_left - NW_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_words == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            rom_cs      <= 1'b1;
                            rom_addr    <= start_addr;
                            addr_q      <= start_addr + ADDR_WIDTH'(1);
                            issue_left  <= num_words - NW_W'(1);
                            accept_left <= num_words;
                            state       <= (num_words == NW_W'(1)) ? ST_DRAIN : ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (credit_ok) begin
                        rom_cs     <= 1'b1;
                        rom_addr   <= addr_q;
                        addr_q     <= addr_q + ADDR_WIDTH'(1);
                        issue_left <= issue_left - NW_W'(1);
                        if (issue_left == NW_W'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && (accept_left == NW_W'(1))) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ROM_STREAM_CHECKSUM_EN
    // Running sum of accepted words, cleared on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if ((state == ST_IDLE) && start) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + 16'(out_data);
        end
    end
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader: table of sweeps plus reset, zero-length and full-image cases.
module tb_rom_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  start_addr;
    logic [10:0] num_words;
    logic        busy;
    logic        done;
    logic        rom_cs;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_dout;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [15:0] checksum;

    int n_vec  = 0;
    int n_fail = 0;

    rom_stream_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .num_words  (num_words),
        .busy       (busy),
        .done       (done),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_val(input logic [9:0] a);
        logic [9:0] t;
        t = a * 10'd37 + 10'd11;
        return t[7:0] ^ {a[9:8], a[5:0]};
    endfunction

    // Two-cycle ROM wrapper; filler value when unselected exposes mis-timed captures.
    logic [7:0] rom_s1;
    always @(posedge clk) begin
        rom_s1   <= rom_cs ? rom_val(rom_addr) : 8'h5A;
        rom_dout <= rom_s1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0]  sa;
        logic [10:0] nw;
        int          stall_len;
        int          exp_valid;
        int          exp_done;
    } vec_t;

    vec_t vecs[5];

    task automatic run_sweep(input vec_t v, input string name);
        int          cyc, fv, dc, issued, received, maxout, limit;
        logic [15:0] sum;
        logic [9:0]  ea;
        start      = 1'b1;
        start_addr = v.sa;
        num_words  = v.nw;
        out_ready  = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1; fv = -1; dc = -1; issued = 0; received = 0; maxout = 0; sum = '0;
        limit = 4 * int'(v.nw) + v.stall_len + 50;
        while (dc < 0 && cyc < limit) begin
            if (rom_cs) begin
                ea = v.sa + 10'(issued);
                chk({name, " addr"}, 32'(rom_addr), 32'(ea));
                issued++;
            end
            if (issued - received > maxout) maxout = issued - received;
            if (out_valid && fv < 0) fv = cyc;
            out_ready = !(fv >= 0 && cyc < fv + v.stall_len);
            if (out_valid && out_ready) begin
                ea = v.sa + 10'(received);
                chk({name, " data"}, 32'(out_data), 32'(rom_val(ea)));
                sum = sum + 16'(rom_val(ea));
                received++;
            end
            if (done) dc = cyc;
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        if (dc < 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s timeout: no done after %0d cycles, required done", name, cyc);
        end
        chk({name, " first_valid_cycle"}, 32'(fv), 32'(v.exp_valid));
        chk({name, " done_cycle"}, 32'(dc), 32'(v.exp_done));
        chk({name, " words_received"}, 32'(received), 32'(v.nw));
        chk({name, " words_issued"}, 32'(issued), 32'(v.nw));
        chk({name, " outstanding_le_depth"}, 32'(maxout <= 4), 32'd1);
        chk({name, " busy_after"}, 32'(busy), 32'd0);
`ifdef ROM_STREAM_CHECKSUM_EN
        chk({name, " checksum"}, 32'(checksum), 32'(sum));
`else
        chk({name, " checksum"}, 32'(checksum), 32'd0);
`endif
    endtask

    initial begin
        int stale;
        vec_t full;
        vecs[0] = '{10'h000, 11'd4,  0,  4, 8};
        vecs[1] = '{10'h3FE, 11'd4,  0,  4, 8};
        vecs[2] = '{10'h100, 11'd16, 10, 4, 30};
        vecs[3] = '{10'h3F0, 11'd1,  0,  4, 5};
        vecs[4] = '{10'h3FF, 11'd2,  1,  4, 7};

        rst = 1'b1; start = 1'b0; start_addr = '0; num_words = '0; out_ready = 1'b1;
        tick(); tick(); tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset rom_cs", 32'(rom_cs), 32'd0);
        chk("reset rom_addr", 32'(rom_addr), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset checksum", 32'(checksum), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_sweep(vecs[i], $sformatf("vec%0d", i));
            tick();
        end

        // Zero-length sweep: done in cycle 1, never touches the ROM.
        start = 1'b1; start_addr = 10'h055; num_words = 11'd0;
        tick();
        start = 1'b0;
        chk("zero done_c1", 32'(done), 32'd1);
        chk("zero rom_cs_c1", 32'(rom_cs), 32'd0);
        tick();
        chk("zero done_c2", 32'(done), 32'd0);
        chk("zero busy_c2", 32'(busy), 32'd0);
        chk("zero rom_cs_c2", 32'(rom_cs), 32'd0);
        chk("zero checksum", 32'(checksum), 32'd0);
        tick();

        // Reset in cycle 3 of a 32-word sweep.
        start = 1'b1; start_addr = 10'h010; num_words = 11'd32;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("midrst busy_c3", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst rom_cs", 32'(rom_cs), 32'd0);
        chk("midrst rom_addr", 32'(rom_addr), 32'd0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_data", 32'(out_data), 32'd0);
        chk("midrst checksum", 32'(checksum), 32'd0);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid || done || rom_cs || busy) stale++;
        end
        chk("midrst stale_activity", 32'(stale), 32'd0);
        run_sweep(vecs[0], "post_reset");
        tick();

        full = '{10'h000, 11'd1024, 0, 4, 1028};
        run_sweep(full, "full_image");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_stream_reader.md
# rom_stream_reader

Read sequencer sitting directly upstream of the 8x1024 ROM wrapper. On a start pulse it sweeps a contiguous address range, driving the wrapper's chip select and address once per cycle. It tracks the fixed ROM read latency, buffers returning words in a small FIFO, and presents them on a valid/ready stream toward the test-chip readout logic, with optional running checksum.

## Interface
Parameters:
- DATA_WIDTH, 8, ROM word width
- ADDR_WIDTH, 10, ROM address width
- ROM_LATENCY, 2, cycles from rom_cs high in cycle k to rom_dout valid for capture at the end of cycle k+ROM_LATENCY
- FIFO_DEPTH, 4, output buffer entries; must be >= ROM_LATENCY+1

Ports:
- clk  in  1  sole clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin sweep; sampled only in IDLE
- start_addr  in  ADDR_WIDTH  first address, sampled with start
- num_words  in  ADDR_WIDTH+1  word count 0..2^ADDR_WIDTH, sampled with start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at sweep end
- rom_cs  out  1  to wrapper cs, registered
- rom_addr  out  ADDR_WIDTH  to wrapper addr, registered
- rom_dout  in  DATA_WIDTH  from wrapper dout
- out_valid  out  1  stream word available
- out_ready  in  1  consumer accepts
- out_data  out  DATA_WIDTH  FIFO head word
- checksum  out  16  running sum of accepted words

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches start_addr/num_words, clears checksum, enters RUN; if num_words=0 enters DONE directly, no ROM access.
- RUN: issue read (rom_cs=1, rom_addr=current address) when fifo_count + inflight < FIFO_DEPTH; otherwise rom_cs=0. Address increments by 1 per issue, wrapping 2^ADDR_WIDTH-1 -> 0. After issuing the last word -> DRAIN.
- inflight tracked by a ROM_LATENCY-deep tag shift register; a tag reaching the end writes rom_dout into FIFO. Credit rule guarantees the FIFO never overflows; no data is dropped.
- DRAIN: no issues; when inflight=0, FIFO empty, and all num_words accepted -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- start outside IDLE ignored.
- FIFO: out_valid = fifo not empty; pop on out_valid && out_ready; simultaneous push and pop keeps count unchanged; pop from a full FIFO with push in the same cycle is legal.
- Checksum: on every accepted word, checksum <= checksum + zero-extended out_data, mod 2^16; holds after done until next start.

## Timing
- Reset values: busy=0, done=0, rom_cs=0, rom_addr=0, out_valid=0, out_data=0, checksum=0; FIFO, tags, counters cleared.
- Reset mid-sweep: returns to IDLE next cycle; in-flight returns discarded (tags cleared), no done pulse.
- start at cycle 0 -> busy=1 and first rom_cs=1 in cycle 1 with rom_addr=start_addr.
- Capture at end of cycle 1+ROM_LATENCY; out_valid first high in cycle 2+ROM_LATENCY (cycle 4 at defaults).
- out_ready held high: one word per cycle sustained, no bubbles.
- Last word accepted in cycle n -> DONE (done=1) in cycle n+1, IDLE/busy=0 in cycle n+2.

## Configuration
- ROM_STREAM_CHECKSUM_EN defined: checksum adder built, checksum behaves as above.
- Not defined: no adder; checksum tied to 16'h0000; all other behaviour identical.

## Test plan
- Reset then start, start_addr=0x000, num_words=4, out_ready=1 -> rom_addr 0,1,2,3 in cycles 1-4; out_valid cycles 4-7 carrying ROM[0..3]; done in cycle 8.
- start_addr=0x3FE, num_words=4 -> rom_addr sequence 0x3FE,0x3FF,0x000,0x001; data ROM[0x3FE],ROM[0x3FF],ROM[0],ROM[1].
- num_words=16, out_ready low for 10 cycles after first valid -> rom_cs stops after FIFO_DEPTH outstanding words; on release all 16 words delivered in order, none lost or duplicated.
- num_words=0 -> done pulse in cycle 1, rom_cs never asserted, checksum=0.
- rst asserted in cycle 3 of a 32-word sweep -> all outputs at reset values from cycle 4; no stale out_valid; new start afterwards operates normally.
- With ROM_STREAM_CHECKSUM_EN, full sweep num_words=1024 -> checksum equals 16-bit sum of image; without macro checksum=0.
